// File: rtl/spi_flash_target_if.sv
// Purpose : SPI pin bundle plus host preload and status lines for the flash-emulating target.
// Latency : none (wires only).
// Backpressure: none; SPI is controller-paced and preload is a single-cycle strobe.
// Ports   : i_cs/i_sclk/i_copi/o_cipo SPI pins; i_ld_en/i_ld_addr/i_ld_data preload;
//           o_cmd/o_cmd_stb/o_wel status. master = controller/host side, slave = target side.
interface spi_flash_target_if #(
    parameter int ADDR_SZ = 8
);
    logic               i_cs;
    logic               i_sclk;
    logic               i_copi;
    logic               o_cipo;
    logic               i_ld_en;
    logic [ADDR_SZ-1:0] i_ld_addr;
    logic [7:0]         i_ld_data;
    logic [7:0]         o_cmd;
    logic               o_cmd_stb;
    logic               o_wel;

    modport master (
        output i_cs, i_sclk, i_copi, i_ld_en, i_ld_addr, i_ld_data,
        input  o_cipo, o_cmd, o_cmd_stb, o_wel
    );

    modport slave (
        input  i_cs, i_sclk, i_copi, i_ld_en, i_ld_addr, i_ld_data,
        output o_cipo, o_cmd, o_cmd_stb, o_wel
    );
endinterface

// File: rtl/spi_flash_target.sv
// Purpose : SPI mode-0 target emulating a small NOR flash (READ/PROG/RDID/RDSR/WREN/WRDI).
// Latency : SPI pin to internal event 3 i_clk cycles; o_cipo updates 3 cycles after SCLK fall.
// Backpressure: none; the controller paces everything, preload accepted only while deselected.
// Ports   : i_clk, i_rst_n (async active-low); bus = slave modport of spi_flash_target_if.
module spi_flash_target #(
    parameter int          ADDR_SZ  = 8,
    parameter logic [23:0] JEDEC_ID = 24'hC84015
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    spi_flash_target_if.slave bus
);
    localparam logic [7:0] C_READ = 8'h03;
    localparam logic [7:0] C_PROG = 8'h02;
    localparam logic [7:0] C_RDID = 8'h9F;
    localparam logic [7:0] C_RDSR = 8'h05;
    localparam logic [7:0] C_WREN = 8'h06;
    localparam logic [7:0] C_WRDI = 8'h04;
    localparam logic [ADDR_SZ-1:0] C_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_READ, S_PROG, S_RDID, S_RDSR, S_IGNORE
    } state_t;

    state_t             r_state;
    logic [1:0]         r_cs_sync, r_sclk_sync, r_copi_sync;
    logic               r_cs_prev, r_sclk_prev;
    logic [7:0]         r_mem [0:(1<<ADDR_SZ)-1];
    logic [4:0]         r_bit_cnt;
    logic [2:0]         r_out_cnt;
    logic [6:0]         r_shift;
    logic [7:0]         r_out;
    logic [ADDR_SZ-1:0] r_addr;
    logic               r_is_read, r_prog_ok, r_committed;
    logic [1:0]         r_id_idx;
    logic               r_cipo, r_cmd_stb, r_wel;
    logic [7:0]         r_cmd;

    logic               w_cs, w_sclk, w_copi;
    logic               w_sclk_rise, w_sclk_fall, w_cs_fall;
    logic [7:0]         w_byte_in;
    logic [ADDR_SZ-1:0] w_addr_nx, w_addr_inc;
    logic               w_prog_we, w_ld_we;

    assign w_cs        = r_cs_sync[1];
    assign w_sclk      = r_sclk_sync[1];
    assign w_copi      = r_copi_sync[1];
    // Edges come from comparing the synchronised sample with its registered copy.
    assign w_sclk_rise = w_sclk & ~r_sclk_prev;
    assign w_sclk_fall = ~w_sclk & r_sclk_prev;
    assign w_cs_fall   = ~w_cs & r_cs_prev;
    assign w_byte_in   = {r_shift, w_copi};
    // Shifting into an ADDR_SZ-wide register keeps only the low address bits.
    assign w_addr_nx   = {r_addr[ADDR_SZ-2:0], w_copi};
    assign w_addr_inc  = r_addr + C_ONE;

    // Deselect has priority, so a byte cut short by CS rise never commits.
    assign w_prog_we = (r_state == S_PROG) && !w_cs && w_sclk_rise && (r_bit_cnt == 5'd7);
    // Both the raw pin and the synchronised state must show deselected.
    assign w_ld_we   = bus.i_ld_en && bus.i_cs && w_cs && (r_state == S_IDLE);

    assign bus.o_cipo    = r_cipo;
    assign bus.o_cmd     = r_cmd;
    assign bus.o_cmd_stb = r_cmd_stb;
    assign bus.o_wel     = r_wel;

    // Backing store is not reset; NOR programming can only clear bits.
    always_ff @(posedge i_clk) begin
        if (w_prog_we)
            r_mem[r_addr] <= r_mem[r_addr] & w_byte_in;
        else if (w_ld_we)
            r_mem[bus.i_ld_addr] <= bus.i_ld_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // CS chain resets low so that a reset never fabricates a CS fall.
            r_cs_sync   <= 2'b00;
            r_sclk_sync <= 2'b00;
            r_copi_sync <= 2'b00;
            r_cs_prev   <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_state     <= S_IDLE;
            r_bit_cnt   <= 5'd0;
            r_out_cnt   <= 3'd0;
            r_shift     <= 7'd0;
            r_out       <= 8'd0;
            r_addr      <= '0;
            r_is_read   <= 1'b0;
            r_prog_ok   <= 1'b0;
            r_committed <= 1'b0;
            r_id_idx    <= 2'd0;
            r_cipo      <= 1'b0;
            r_cmd_stb   <= 1'b0;
            r_wel       <= 1'b0;
            r_cmd       <= 8'h00;
        end else begin
            r_cs_sync   <= {r_cs_sync[0], bus.i_cs};
            r_sclk_sync <= {r_sclk_sync[0], bus.i_sclk};
            r_copi_sync <= {r_copi_sync[0], bus.i_copi};
            r_cs_prev   <= w_cs;
            r_sclk_prev <= w_sclk;
            r_cmd_stb   <= 1'b0;

            if (w_cs) begin
                if (r_state == S_PROG && r_committed)
                    r_wel <= 1'b0;
                r_state <= S_IDLE;
                r_cipo  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_cs_fall) begin
                            r_state     <= S_CMD;
                            r_bit_cnt   <= 5'd0;
                            r_cipo      <= 1'b0;
                            r_committed <= 1'b0;
                        end
                    end
                    S_CMD: begin
                        if (w_sclk_rise) begin
                            r_shift   <= w_byte_in[6:0];
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == 5'd7) begin
                                r_cmd     <= w_byte_in;
                                r_cmd_stb <= 1'b1;
                                r_bit_cnt <= 5'd0;
                                r_out_cnt <= 3'd0;
                                case (w_byte_in)
                                    C_READ: begin r_state <= S_ADDR; r_is_read <= 1'b1; end
                                    C_PROG: begin
                                        r_state   <= S_ADDR;
                                        r_is_read <= 1'b0;
                                        r_prog_ok <= r_wel;
                                    end
                                    C_RDID: begin
                                        r_state  <= S_RDID;
                                        r_out    <= JEDEC_ID[23:16];
                                        r_id_idx <= 2'd1;
                                    end
                                    C_RDSR: begin
                                        r_state <= S_RDSR;
                                        r_out   <= {6'b0, r_wel, 1'b0};
                                    end
                                    C_WREN:  begin r_state <= S_IGNORE; r_wel <= 1'b1; end
                                    C_WRDI:  begin r_state <= S_IGNORE; r_wel <= 1'b0; end
                                    default: r_state <= S_IGNORE;
                                endcase
                            end
                        end
                    end
                    S_ADDR: begin
                        if (w_sclk_rise) begin
                            r_addr    <= w_addr_nx;
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == 5'd23) begin
                                r_bit_cnt <= 5'd0;
                                r_out_cnt <= 3'd0;
                                if (r_is_read) begin
                                    r_state <= S_READ;
                                    r_out   <= r_mem[w_addr_nx];
                                end else begin
                                    r_state <= r_prog_ok ? S_PROG : S_IGNORE;
                                end
                            end
                        end
                    end
                    S_PROG: begin
                        if (w_sclk_rise) begin
                            r_shift   <= w_byte_in[6:0];
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            if (r_bit_cnt == 5'd7) begin
                                r_bit_cnt   <= 5'd0;
                                r_addr      <= w_addr_inc;
                                r_committed <= 1'b1;
                            end
                        end
                    end
                    S_READ, S_RDID, S_RDSR: begin
                        if (w_sclk_fall) begin
                            r_cipo    <= r_out[7];
                            r_out     <= {r_out[6:0], 1'b0};
                            r_out_cnt <= r_out_cnt + 3'd1;
                            // Eighth fall has put the last bit out: fetch the next byte.
                            if (r_out_cnt == 3'd7) begin
                                if (r_state == S_READ) begin
                                    r_addr <= w_addr_inc;
                                    r_out  <= r_mem[w_addr_inc];
                                end else if (r_state == S_RDSR) begin
                                    r_out <= {6'b0, r_wel, 1'b0};
                                end else begin
                                    case (r_id_idx)
                                        2'd0:    begin r_out <= JEDEC_ID[23:16]; r_id_idx <= 2'd1; end
                                        2'd1:    begin r_out <= JEDEC_ID[15:8];  r_id_idx <= 2'd2; end
                                        default: begin r_out <= JEDEC_ID[7:0];   r_id_idx <= 2'd0; end
                                    endcase
                                end
                            end
                        end
                    end
                    default: r_cipo <= 1'b0;
                endcase
            end
        end
    end
endmodule

// File: doc/spi_flash_target.md
Name: spi_flash_target

Overview:
- SPI mode-0 target that emulates a small serial NOR flash device.
- It is the responder end of the link driven by the `flash` controller. It connects to the controller's CS/SCLK/COPI/CIPO wires in simulation and on loop-back FPGA test builds.
- All SPI inputs are oversampled by the system clock; there are no SCLK-clocked flops.
- Backing store is a byte RAM. A host-side preload port fills it while the target is deselected.

Parameters:
- ADDR_SZ, 8, log2 of memory depth in bytes. Flash address bits above ADDR_SZ are ignored.
- JEDEC_ID, 24'hC84015, 3-byte ID returned by RDID, MSB byte first.

Ports:
- i_clk  in  1  system clock; must be at least 4x the SCLK frequency.
- i_rst_n  in  1  asynchronous active-low reset.
- i_cs  in  1  SPI chip select, active low.
- i_sclk  in  1  SPI clock, idle low.
- i_copi  in  1  controller-out data.
- o_cipo  out  1  controller-in data.
- i_ld_en  in  1  preload write strobe.
- i_ld_addr  in  ADDR_SZ  preload address.
- i_ld_data  in  8  preload data.
- o_cmd  out  8  last decoded command byte.
- o_cmd_stb  out  1  one-cycle pulse when a command byte completes.
- o_wel  out  1  write-enable latch.

Behaviour:
- Reset values: o_cipo=0, o_cmd=8'h00, o_cmd_stb=0, o_wel=0, state=IDLE. Memory contents are not reset.
- Input synchronisation:
  - i_cs, i_sclk and i_copi each pass through a 2-FF synchroniser.
  - The SCLK rise/fall event is a registered compare of synchronised samples.
  - Pin-to-event latency is 3 i_clk cycles.
- Bit timing: COPI is sampled on SCLK rise. CIPO shifts on SCLK fall. All data is MSB first.
- CS fall (synchronised):
  - bit counter=0, state=CMD.
  - o_cipo=0 until the first data byte is loaded.
- CS high at any time (including mid-byte or mid-address): return to IDLE and discard any partial byte.
  - If the transaction was PROG and at least one byte was committed, clear WEL.
- States:
  - IDLE → CMD on CS fall.
  - CMD: shift 8 bits. On the 8th rise, set o_cmd, pulse o_cmd_stb, then decode:
    - 8'h03 → ADDR, then READ.
    - 8'h02 → ADDR, then PROG if WEL=1, else IGNORE.
    - 8'h9F → RDID; load JEDEC_ID[23:16] as the out byte.
    - 8'h05 → RDSR; load {6'b0, WEL, 1'b0} as the out byte.
    - 8'h06 → set WEL, then IGNORE.
    - 8'h04 → clear WEL, then IGNORE.
    - Any other value → IGNORE.
  - ADDR: shift 24 bits; addr = low ADDR_SZ bits. On the 24th rise, enter READ (and load mem[addr] as the out byte) or PROG/IGNORE as decoded.
  - READ: the MSB of the out byte is driven on o_cipo at the SCLK fall following the last address/command bit.
    - After each 8 falls, addr += 1 (wrapping modulo 2^ADDR_SZ) and load mem[addr].
    - Streaming continues until CS rises.
  - RDID: outputs ID bytes 23:16, 15:8, 7:0, then repeats 23:16.
  - RDSR: repeats the status byte, re-sampled at each byte boundary.
  - PROG: each completed byte writes mem[addr] = mem[addr] & data (NOR semantics: bits only clear). addr then increments with wrap.
  - IGNORE: o_cipo=0; wait for CS high.
- Preload:
  - i_ld_en with CS high writes i_ld_data to mem[i_ld_addr] in 1 cycle (plain write, no AND).
  - i_ld_en is ignored while CS is low.
  - A preload and a PROG commit on the same cycle cannot occur, because the two are CS-exclusive.
- Reset mid-transaction: immediate return to reset values. The next transaction requires a fresh CS fall.

Test Plan:
1. Preload mem[0x10..0x13] with 11,22,33,44. Send CS low, 03 00 00 10, then 4 dummy bytes → CIPO bytes 11 22 33 44; o_cmd=03; o_cmd_stb pulses once.
2. Send 9F plus 4 dummy bytes → C8 40 15 C8. Then 05 plus 1 dummy byte → 00.
3. With mem[0x20]=FF:
   - Send 06, CS high. Then 05 → 02.
   - Send 02 00 00 20 5A, CS high → mem[0x20]=5A; subsequent 05 → 00.
   - Send 02 00 00 20 FF without 06 → mem[0x20] stays 5A.
4. With ADDR_SZ=8, mem[0xFF]=AA and mem[0x00]=BB: read from 0x0000FF for 2 bytes → AA BB (wrap). Address 0x1234FF behaves identically.
5. Raise CS after 12 address bits of a READ, then send 9F → C8 returned. No residual state; o_cipo=0 while deselected.
6. Assert i_rst_n=0 mid-READ stream → all outputs at reset values immediately. Preload during CS low → memory unchanged.
